// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, LSB first, one bit per clock, registered carry.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic              carry_q, carry_d, co_q, co_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_sum, fa_co, last_bit;
  logic [WIDTH:0]    sum_shift;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in s[0].
  assign sum_shift = {fa_sum, s_q};
  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          s_d     = '0;
          co_d    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = sum_shift[WIDTH:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          state_d = StDone;
          co_d    = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the sign bit differs from carry out of it.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus reset, disturbance and
// back-to-back sequences. Checks ovf too when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ci = 1'b0;
  logic         busy, done, co;
  logic [W-1:0] s;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one operation; disturb scrambles inputs and pulses start during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic disturb, output logic [W-1:0] rs, output logic rco,
                        output logic rovf, output int busy_cyc, output int done_cyc,
                        output int lat);
    busy_cyc = 0;
    done_cyc = 0;
    lat      = -1;
    rs       = 'x;
    rco      = 1'bx;
    rovf     = 1'bx;
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    @(posedge clk);
    #1;
    check("accept_clears_s", 32'(s), 32'h0);
    check("accept_clears_co", 32'(co), 32'h0);
    start = 1'b0;
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        if (lat < 0) begin
          lat  = n;
          rs   = s;
          rco  = co;
          rovf = get_ovf();
        end
      end
      if (n == W + 3) begin
        check("s_held_after_done", 32'(s), 32'(rs));
        check("co_held_after_done", 32'(co), 32'(rco));
      end
      if (disturb) begin
        if (n < W) begin
          a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
          start = (n == 3);
        end else begin
          start = 1'b0;
        end
      end
    end
    if (lat < 0) $display("FAIL no_done: got no done pulse, expected one within %0d cycles", W + 6);
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] rs;
    logic         rco, rovf;
    int           bc, dc, lat, accepts, dones, last_acc;
    logic         busy_prev;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_s", 32'(s), 32'h0);
    check("rst_co", 32'(co), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, rs, rco, rovf, bc, dc, lat);
      check($sformatf("v%0d_s", i), 32'(rs), 32'(vecs[i].exp_s));
      check($sformatf("v%0d_co", i), 32'(rco), 32'(vecs[i].exp_co));
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(rovf), 32'(vecs[i].exp_ovf));
`endif
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), W);
      check($sformatf("v%0d_done_cycles", i), 32'(dc), 32'd1);
      check($sformatf("v%0d_latency", i), 32'(lat), W + 1);
    end

    // Inputs scrambled and start pulsed during RUN
    run_op(8'h12, 8'h34, 1'b0, 1'b1, rs, rco, rovf, bc, dc, lat);
    check("disturb_s", 32'(rs), 32'h46);
    check("disturb_co", 32'(rco), 32'h0);
    check("disturb_done_cycles", 32'(dc), 32'd1);
    check("disturb_busy_cycles", 32'(bc), W);

    // Reset at RUN cycle 4
    @(negedge clk);
    a = 8'h5A; b = 8'h11; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_s", 32'(s), 32'h0);
    check("abort_co", 32'(co), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 32'(ovf), 32'h0);
`endif
    dones = 0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (n == 2) rst_n = 1'b1;
    end
    check("abort_no_done", 32'(dones), 32'h0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, rs, rco, rovf, bc, dc, lat);
    check("post_abort_s", 32'(rs), 32'h02);
    check("post_abort_latency", 32'(lat), W + 1);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h02; ci = 1'b0; start = 1'b1;
    accepts = 0; dones = 0; last_acc = -1; busy_prev = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (busy && !busy_prev) begin
        if (last_acc >= 0) check("b2b_spacing", 32'(n - last_acc), W + 2);
        last_acc = n;
        accepts++;
      end
      if (done) begin
        dones++;
        check("b2b_s", 32'(s), 32'h03);
      end
      busy_prev = busy;
    end
    start = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd4);
    check("b2b_dones", 32'(dones), 32'd3);
    repeat (W + 4) @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and give the operand and result width in bits; legal range is 1..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin one addition, sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 ci  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when s and co become valid.
REQ-010 s  output  WIDTH  sum result.
REQ-011 co  output  1  carry-out result.

Function
REQ-012 The block SHALL add bit-serially, LSB first, one bit per clock, through one instance of the team's full_adder cell, with a registered carry.
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on the edge where start=1 is sampled; that edge SHALL load the operand shift registers from a and b, the carry register from ci, and clear the bit counter.
REQ-015 Each RUN edge SHALL add the current LSBs of A and B with the carry register, shift the sum bit into the result register from the MSB side, shift the operands right, update the carry and increment the counter.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1, so RUN lasts exactly WIDTH cycles.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 done SHALL be high only in DONE (exactly one cycle), which is WIDTH+1 cycles after the start-accept edge.
REQ-019 When done is high, s SHALL equal (a+b+ci) mod 2^WIDTH and co SHALL equal bit WIDTH of a+b+ci.
REQ-020 s and co SHALL hold their values from DONE until the next start-accept edge, where they SHALL clear to 0.
REQ-021 start SHALL be ignored in RUN and DONE, and no request SHALL be queued.
REQ-022 Changes on a, b or ci after the accept edge SHALL NOT affect the result.
REQ-023 WIDTH=1 SHALL give one RUN cycle and done two cycles after accept.
REQ-024 s and co SHALL change only on the accept edge and on RUN edges; while computing, s SHALL show the partial shifted value, which is valid only when done=1.

Reset
REQ-025 rst_n low SHALL immediately force IDLE and set busy=0, done=0, s=0, co=0, carry=0, counter=0, operand registers=0, and ovf=0 when present.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse, and the first start after release SHALL behave as from power-up.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined SHALL add the output port ovf  output  1  signed overflow.
REQ-028 With the macro defined, ovf SHALL be set on the RUN -> DONE edge to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), held and cleared exactly like co.
REQ-029 With the macro undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 Apply a=0x3C, b=0x05, ci=0 with start -> busy for 8 cycles, then done for 1 cycle with s=0x41, co=0.
REQ-031 Apply a=0xFF, b=0x01, ci=0 -> s=0x00, co=1; then a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1.
REQ-032 Pulse start and randomise a, b, ci during RUN -> the result matches the operands captured at accept; the RUN start pulse produces no extra done.
REQ-033 Assert rst_n low at RUN cycle 4 -> all outputs are 0 at once with no done; a new start (a=0x01, b=0x01) gives s=0x02.
REQ-034 With SERIAL_ADDER_OVF_EN, 0x7F+0x01 -> s=0x80, co=0, ovf=1; 0x80+0x80 -> s=0x00, co=1, ovf=1; 0x10+0x20 -> ovf=0.
REQ-035 Hold start high continuously -> back-to-back operations, with accept edges exactly WIDTH+2 cycles apart and done pulsing once per operation.
